vec_op_sequencer: RTL and testbench

- Command-driven sequencer for the 4-lane 8-bit vector add datapath.
- Accepts one vector command at a time on a valid/ready handshake and paces serial operand entry on din with a din_valid/din_ready handshake.
- Drives the datapath's per-lane load, add-stage, result and save_c strobes, then pulses done.
- Sits between the host/command source and the datapath; replaces the free-running fixed schedule with a stallable, opcode-selected one.

---
 rtl/vec_op_sequencer_pkg.sv | 24 ++
 rtl/vec_lane_counter.sv | 48 ++++
 rtl/vec_op_sequencer.sv | 145 ++++++++++++++
 tb/tb_vec_op_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_op_sequencer_pkg.sv
// Shared types and constants for the vector-add command sequencer.
package vec_seq_pkg;

    // Lane count used when no override is given at instantiation
    localparam int unsigned LANES_DEFAULT = 4;

    // Command opcodes
    localparam logic [1:0] OP_VADD       = 2'b00;
    localparam logic [1:0] OP_VADD_SAVE  = 2'b01;
    localparam logic [1:0] OP_VADD_KEEPB = 2'b10;
    localparam logic [1:0] OP_ILLEGAL    = 2'b11;

    // Sequencer phases
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_ADD1   = 3'd3,
        ST_ADD2   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage : vec_seq_pkg

// File: rtl/vec_lane_counter.sv
// Lane index counter shared by both operand load phases: counts 0..LANES-1,
// wraps to 0 after the last lane, and exposes a one-hot decode plus last flag.
module vec_lane_counter
    import vec_seq_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEFAULT,
    parameter int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [LANES-1:0] onehot_o,
    output logic             last_o
);

    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] lane_d;

    // Lane register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Next lane: clear wins over increment; the last lane wraps back to 0
    always_comb begin
        lane_d = lane_q;
        if (clr_i) begin
            lane_d = '0;
        end else if (inc_i) begin
            lane_d = last_o ? '0 : lane_q + LANE_W'(1);
        end
    end

    // One-hot decode of the current lane and last-lane flag
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            onehot_o[i] = (lane_q == LANE_W'(i));
        end
        last_o = (lane_q == LANE_W'(LANES - 1));
    end

endmodule : vec_lane_counter

// File: rtl/vec_op_sequencer.sv
// Command-driven sequencer for the 4-lane vector add datapath. Accepts one
// command, paces serial operand entry, then steps the add/write strobes and
// pulses done. All strobes are decoded from the registered phase.
module vec_op_sequencer
    import vec_seq_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [LANES-1:0] en_a,
    output logic [LANES-1:0] en_b,
    output logic [LANES-1:0] en_add1,
    output logic [LANES-1:0] en_add2,
    output logic [LANES-1:0] en_f,
    output logic             save_c,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;

    logic             lane_clr;
    logic             lane_inc;
    logic [LANES-1:0] lane_onehot;
    logic             lane_last;

    vec_lane_counter #(
        .LANES (LANES)
    ) u_lane_counter (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (lane_clr),
        .inc_i    (lane_inc),
        .onehot_o (lane_onehot),
        .last_o   (lane_last)
    );

    // Phase, latched opcode and illegal-opcode pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_VADD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next phase, opcode capture and lane counter control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = 1'b0;
        lane_clr = 1'b0;
        lane_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        op_d     = cmd_op;
                        lane_clr = 1'b1;
                        state_d  = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                if (din_valid) begin
                    lane_inc = 1'b1;
                    if (lane_last) begin
                        state_d = (op_q == OP_VADD_KEEPB) ? ST_ADD1 : ST_LOAD_B;
                    end
                end
            end
            ST_LOAD_B: begin
                if (din_valid) begin
                    lane_inc = 1'b1;
                    if (lane_last) begin
                        state_d = ST_ADD1;
                    end
                end
            end
            ST_ADD1:  state_d = ST_ADD2;
            ST_ADD2:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobe and status decode from the current phase
    always_comb begin
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        en_a      = '0;
        en_b      = '0;
        en_add1   = '0;
        en_add2   = '0;
        en_f      = '0;
        save_c    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD_A: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    en_a = lane_onehot;
                end
            end
            ST_LOAD_B: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    en_b = lane_onehot;
                end
            end
            ST_ADD1:  en_add1 = '1;
            ST_ADD2:  en_add2 = '1;
            ST_WRITE: begin
                en_f   = '1;
                save_c = (op_q == OP_VADD_SAVE);
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign err = err_q;

endmodule : vec_op_sequencer

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench for vec_op_sequencer: per-cycle expected outputs are
// queued as stimulus is applied and popped when the cycle's outputs settle.
module tb_vec_op_sequencer;
    import vec_seq_pkg::*;

    localparam int unsigned L = 4;

    typedef enum int {
        T_IDLE, T_IDLE_ERR, T_LA, T_LB, T_ADD1, T_ADD2, T_WRITE, T_WRITE_SAVE, T_DONE
    } tag_e;

    typedef struct {
        logic       r;
        logic       cv;
        logic [1:0] op;
        logic       dv;
        tag_e       tag;
        int         lane;
    } step_t;

    typedef logic [25:0] obs_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic         cmd_ready;
    logic         din_valid;
    logic         din_ready;
    logic [L-1:0] en_a, en_b, en_add1, en_add2, en_f;
    logic         save_c, busy, done, err;

    obs_t  sb[$];
    step_t steps[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  done_prev = 1'b0;

    always #5 clk = ~clk;

    vec_op_sequencer #(.LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .en_a      (en_a),
        .en_b      (en_b),
        .en_add1   (en_add1),
        .en_add2   (en_add2),
        .en_f      (en_f),
        .save_c    (save_c),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    obs_t obs;
    assign obs = {cmd_ready, din_ready, busy, done, err, save_c,
                  en_a, en_b, en_add1, en_add2, en_f};

    // Expected outputs for one cycle, given the phase the spec places it in
    function automatic obs_t mk(tag_e t, int lane, logic dv);
        logic [3:0] oh;
        logic       cr, dr, bz, dn, er, sc;
        logic [3:0] a, b, a1, a2, f;
        oh = 4'(1 << lane);
        cr = 1'b0; dr = 1'b0; bz = 1'b1; dn = 1'b0; er = 1'b0; sc = 1'b0;
        a = '0; b = '0; a1 = '0; a2 = '0; f = '0;
        case (t)
            T_IDLE:       begin cr = 1'b1; bz = 1'b0; end
            T_IDLE_ERR:   begin cr = 1'b1; bz = 1'b0; er = 1'b1; end
            T_LA:         begin dr = 1'b1; a = dv ? oh : 4'b0000; end
            T_LB:         begin dr = 1'b1; b = dv ? oh : 4'b0000; end
            T_ADD1:       a1 = 4'b1111;
            T_ADD2:       a2 = 4'b1111;
            T_WRITE:      f = 4'b1111;
            T_WRITE_SAVE: begin f = 4'b1111; sc = 1'b1; end
            T_DONE:       dn = 1'b1;
            default:      ;
        endcase
        return {cr, dr, bz, dn, er, sc, a, b, a1, a2, f};
    endfunction

    function automatic step_t S(logic r, logic cv, logic [1:0] op, logic dv, tag_e t, int lane);
        step_t s;
        s.r = r; s.cv = cv; s.op = op; s.dv = dv; s.tag = t; s.lane = lane;
        return s;
    endfunction

    // Drive one cycle of inputs, queue its expectation, wait for outputs to settle
    task automatic apply(input step_t s);
        rst       = s.r;
        cmd_valid = s.cv;
        cmd_op    = s.op;
        din_valid = s.dv;
        sb.push_back(mk(s.tag, s.lane, s.dv));
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Appends a full, unstalled command from acceptance through the return to IDLE
    task automatic push_full(input logic [1:0] op);
        steps.push_back(S(0, 1, op, 1, T_IDLE, 0));
        for (int l = 0; l < 4; l++) steps.push_back(S(0, 0, 2'b00, 1, T_LA, l));
        if (op != OP_VADD_KEEPB)
            for (int l = 0; l < 4; l++) steps.push_back(S(0, 0, 2'b00, 1, T_LB, l));
        steps.push_back(S(0, 0, 2'b00, 1, T_ADD1, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_ADD2, 0));
        steps.push_back(S(0, 0, 2'b00, 1, (op == OP_VADD_SAVE) ? T_WRITE_SAVE : T_WRITE, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_DONE, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_IDLE, 0));
    endtask

    task automatic test_reset();
        obs_t e;
        steps.delete();
        steps.push_back(S(1, 0, 2'b00, 0, T_IDLE, 0));
        steps.push_back(S(1, 1, 2'b00, 1, T_IDLE, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_IDLE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // VADD with din_valid always high and cmd_valid held through busy
    task automatic test_vadd();
        obs_t e;
        steps.delete();
        steps.push_back(S(0, 1, OP_VADD, 1, T_IDLE, 0));
        for (int l = 0; l < 4; l++) steps.push_back(S(0, 1, OP_VADD, 1, T_LA, l));
        for (int l = 0; l < 4; l++) steps.push_back(S(0, 1, OP_VADD, 1, T_LB, l));
        steps.push_back(S(0, 1, OP_VADD, 1, T_ADD1, 0));
        steps.push_back(S(0, 1, OP_VADD, 1, T_ADD2, 0));
        steps.push_back(S(0, 1, OP_VADD, 1, T_WRITE, 0));
        steps.push_back(S(0, 0, OP_VADD, 1, T_DONE, 0));
        steps.push_back(S(0, 0, OP_VADD, 1, T_IDLE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL vadd cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // VADD_SAVE with bubbles on cycles 2 and 6
    task automatic test_vadd_save_stall();
        obs_t e;
        steps.delete();
        steps.push_back(S(0, 1, OP_VADD_SAVE, 1, T_IDLE, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_LA, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_LA, 1));
        steps.push_back(S(0, 0, 2'b00, 1, T_LA, 1));
        steps.push_back(S(0, 0, 2'b00, 1, T_LA, 2));
        steps.push_back(S(0, 0, 2'b00, 1, T_LA, 3));
        steps.push_back(S(0, 0, 2'b00, 0, T_LB, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 1));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 2));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 3));
        steps.push_back(S(0, 0, 2'b00, 0, T_ADD1, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_ADD2, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_WRITE_SAVE, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_DONE, 0));
        steps.push_back(S(0, 0, 2'b00, 0, T_IDLE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL vadd_save cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // VADD_KEEPB skips the B load entirely
    task automatic test_keepb();
        obs_t e;
        steps.delete();
        push_full(OP_VADD_KEEPB);
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL keepb cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // Illegal opcode pulses err once, then a VADD runs normally
    task automatic test_illegal();
        obs_t e;
        steps.delete();
        steps.push_back(S(0, 1, OP_ILLEGAL, 1, T_IDLE, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_IDLE_ERR, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_IDLE, 0));
        push_full(OP_VADD);
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL illegal cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // Reset during LOAD_B lane 2 abandons the command; next one restarts at lane 0
    task automatic test_mid_reset();
        obs_t e;
        steps.delete();
        steps.push_back(S(0, 1, OP_VADD, 1, T_IDLE, 0));
        for (int l = 0; l < 4; l++) steps.push_back(S(0, 0, 2'b00, 1, T_LA, l));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_LB, 1));
        steps.push_back(S(1, 0, 2'b00, 1, T_LB, 2));
        steps.push_back(S(0, 0, 2'b00, 1, T_IDLE, 0));
        steps.push_back(S(0, 0, 2'b00, 1, T_IDLE, 0));
        push_full(OP_VADD);
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mid_reset cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // cmd_valid held continuously: second command accepted right after DONE
    task automatic test_back_to_back();
        obs_t e;
        steps.delete();
        for (int k = 0; k < 2; k++) begin
            steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_IDLE, 0));
            for (int l = 0; l < 4; l++) steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_LA, l));
            steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_ADD1, 0));
            steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_ADD2, 0));
            steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_WRITE, 0));
            steps.push_back(S(0, 1, OP_VADD_KEEPB, 1, T_DONE, 0));
        end
        steps.push_back(S(0, 0, 2'b00, 0, T_IDLE, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs, e);
            end
            advance();
        end
    endtask

    // Structural properties checked every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (!$onehot0({|en_a, |en_b, |en_add1, |en_add2, |en_f})) begin
                n_err++;
                $display("FAIL enable_groups: got %b%b%b%b%b expected at most one group",
                         |en_a, |en_b, |en_add1, |en_add2, |en_f);
            end
            n_cmp++;
            if (save_c && (en_f !== 4'b1111)) begin
                n_err++;
                $display("FAIL save_c_with_en_f: got en_f %b expected 1111", en_f);
            end
            n_cmp++;
            if (done && done_prev) begin
                n_err++;
                $display("FAIL done_pulse: got done high two cycles expected one");
            end
            n_cmp++;
            if (busy && cmd_ready) begin
                n_err++;
                $display("FAIL ready_while_busy: got cmd_ready 1 expected 0");
            end
        end
        done_prev <= done;
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_vadd();
        test_vadd_save_stall();
        test_keepb();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vec_op_sequencer
